sfir_tap_sched: RTL and testbench



---
 rtl/sfir_pkg.sv | 25 ++
 rtl/sfir_tap_sched_counter.sv | 23 ++
 rtl/sfir_tap_sched.sv | 116 +++++++++++
 tb/tb_sfir_tap_sched.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/sfir_pkg.sv
// Shared types and default geometry for the symmetric bitstream FIR tap sequencer.
package sfir_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StCalc,
    StDrain,
    StRound,
    StOut
  } sfir_state_t;

  // A counter over 0..lat-1 needs at least one bit, even when lat is 0 or 1.
  function automatic int unsigned drain_width(input int unsigned lat);
    return (lat < 2) ? 1 : $clog2(lat);
  endfunction

  localparam int unsigned NTAPS_DEF   = 512;
  localparam int unsigned MAC_LAT_DEF = 2;
  localparam int unsigned P           = NTAPS_DEF / 2;
  localparam int unsigned IDX_W       = $clog2(NTAPS_DEF);
  localparam int unsigned CADDR_W     = $clog2(P);
  localparam int unsigned DRAIN_W     = drain_width(MAC_LAT_DEF);

endpackage

// File: rtl/sfir_tap_sched_counter.sv
// Modulo counter with synchronous clear and enable; last flags the final count.
module sfir_tap_sched_counter #(
  parameter int unsigned MODULO = 4,
  parameter int unsigned WIDTH  = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] cnt,
  output logic             last
);

  assign last = (cnt == WIDTH'(MODULO - 1));

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= last ? '0 : cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/sfir_tap_sched.sv
// Sequencer for the symmetric FIR datapath: snapshot, walk tap pairs, drain, round, push.
module sfir_tap_sched
  import sfir_pkg::*;
#(
  parameter int unsigned NTAPS   = 512,
  parameter int unsigned MAC_LAT = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       FILTER,
  input  logic                       OutReady,
  output logic                       LoadEn,
  output logic [$clog2(NTAPS)-1:0]   IdxLo,
  output logic [$clog2(NTAPS)-1:0]   IdxHi,
  output logic [$clog2(NTAPS/2)-1:0] CoefAddr,
  output logic                       AccClr,
  output logic                       MacEn,
  output logic                       RoundEn,
  output logic                       Push,
  output logic                       Busy,
  output logic                       Done,
  output logic                       Overrun,
  output logic [CNT_W-1:0]           FrameCnt
);

  localparam int unsigned NumPairs = NTAPS / 2;
  localparam int unsigned IdxW     = $clog2(NTAPS);
  localparam int unsigned CaddrW   = $clog2(NumPairs);
  localparam int unsigned DrainW   = drain_width(MAC_LAT);

  sfir_state_t       state_q;
  logic [DrainW-1:0] drain_q;
  logic              overrun_q;
  logic [CNT_W-1:0]  frame_q;
  logic [CaddrW-1:0] pair_k;
  logic              pair_last;

  // Pair index sits at 0 outside CALC so every frame starts at k=0.
  sfir_tap_sched_counter #(
    .MODULO(NumPairs),
    .WIDTH (CaddrW)
  ) u_pair_cnt (
    .clk (Clock),
    .clr (Reset || (state_q != StCalc)),
    .en  (state_q == StCalc),
    .cnt (pair_k),
    .last(pair_last)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= StIdle;
      drain_q   <= '0;
      overrun_q <= 1'b0;
      frame_q   <= '0;
    end else begin
      if (FILTER && (state_q != StIdle)) overrun_q <= 1'b1;
      case (state_q)
        StIdle:  if (FILTER) state_q <= StLoad;
        StLoad:  state_q <= StCalc;
        StCalc: begin
          if (pair_last) begin
            drain_q <= '0;
            state_q <= (MAC_LAT == 0) ? StRound : StDrain;
          end
        end
        StDrain: begin
          if (drain_q == DrainW'(MAC_LAT - 1)) state_q <= StRound;
          else drain_q <= drain_q + DrainW'(1);
        end
        StRound: state_q <= StOut;
        StOut: begin
          if (OutReady) begin
            frame_q <= frame_q + CNT_W'(1);
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    LoadEn   = 1'b0;
    IdxLo    = '0;
    IdxHi    = '0;
    CoefAddr = '0;
    AccClr   = 1'b0;
    MacEn    = 1'b0;
    RoundEn  = 1'b0;
    Push     = 1'b0;
    Done     = 1'b0;
    case (state_q)
      StLoad:  LoadEn = 1'b1;
      StCalc: begin
        MacEn    = 1'b1;
        AccClr   = (pair_k == '0);
        IdxLo    = IdxW'(pair_k);
        IdxHi    = IdxW'(NTAPS - 1) - IdxW'(pair_k);
        CoefAddr = pair_k;
      end
      StRound: RoundEn = 1'b1;
      StOut: begin
        Push = 1'b1;
        Done = OutReady;
      end
      default: ;
    endcase
  end

  assign Busy     = (state_q != StIdle);
  assign Overrun  = overrun_q;
  assign FrameCnt = frame_q;

endmodule

// File: tb/tb_sfir_tap_sched.sv
// Directed bench: default geometry instance plus a small NTAPS=8, MAC_LAT=0, CNT_W=2 instance.
module tb_sfir_tap_sched;

  logic Clock;
  int   n_total = 0;
  int   n_pass  = 0;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Default instance
  logic        m_reset, m_filter, m_ready;
  logic        m_load, m_accclr, m_macen, m_round, m_push, m_busy, m_done, m_overrun;
  logic [8:0]  m_idxlo, m_idxhi;
  logic [7:0]  m_coef;
  logic [15:0] m_frame;

  sfir_tap_sched u_dut_m (
    .Clock   (Clock),
    .Reset   (m_reset),
    .FILTER  (m_filter),
    .OutReady(m_ready),
    .LoadEn  (m_load),
    .IdxLo   (m_idxlo),
    .IdxHi   (m_idxhi),
    .CoefAddr(m_coef),
    .AccClr  (m_accclr),
    .MacEn   (m_macen),
    .RoundEn (m_round),
    .Push    (m_push),
    .Busy    (m_busy),
    .Done    (m_done),
    .Overrun (m_overrun),
    .FrameCnt(m_frame)
  );

  // Small instance
  logic       s_reset, s_filter, s_ready;
  logic       s_load, s_accclr, s_macen, s_round, s_push, s_busy, s_done, s_overrun;
  logic [2:0] s_idxlo, s_idxhi;
  logic [1:0] s_coef;
  logic [1:0] s_frame;

  sfir_tap_sched #(
    .NTAPS  (8),
    .MAC_LAT(0),
    .CNT_W  (2)
  ) u_dut_s (
    .Clock   (Clock),
    .Reset   (s_reset),
    .FILTER  (s_filter),
    .OutReady(s_ready),
    .LoadEn  (s_load),
    .IdxLo   (s_idxlo),
    .IdxHi   (s_idxhi),
    .CoefAddr(s_coef),
    .AccClr  (s_accclr),
    .MacEn   (s_macen),
    .RoundEn (s_round),
    .Push    (s_push),
    .Busy    (s_busy),
    .Done    (s_done),
    .Overrun (s_overrun),
    .FrameCnt(s_frame)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  // Cycle n is the interval after clock edge n-1; sample #1 after the edge.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    int loads[$];
    int dones;
    logic [1:0] exp_frame[5];
    exp_frame[0] = 2'd1; exp_frame[1] = 2'd2; exp_frame[2] = 2'd3;
    exp_frame[3] = 2'd0; exp_frame[4] = 2'd1;

    m_reset = 1'b1; m_filter = 1'b0; m_ready = 1'b1;
    s_reset = 1'b1; s_filter = 1'b0; s_ready = 1'b1;
    repeat (3) tick();
    m_reset = 1'b0; s_reset = 1'b0;
    tick();

    // Reset state
    check("rst_busy",    32'(m_busy),    0);
    check("rst_push",    32'(m_push),    0);
    check("rst_load",    32'(m_load),    0);
    check("rst_macen",   32'(m_macen),   0);
    check("rst_idxhi",   32'(m_idxhi),   0);
    check("rst_frame",   32'(m_frame),   0);
    check("rst_overrun", 32'(m_overrun), 0);

    // Single frame, OutReady high
    m_filter = 1'b1;
    tick();  // cycle 1
    m_filter = 1'b0;
    check("f1_load", 32'(m_load), 1);
    check("f1_busy", 32'(m_busy), 1);
    check("f1_load_macen", 32'(m_macen), 0);
    for (int c = 2; c <= 257; c++) begin
      tick();
      check("f1_macen",  32'(m_macen),  1);
      check("f1_idxlo",  32'(m_idxlo),  32'(c - 2));
      check("f1_idxhi",  32'(m_idxhi),  32'(511 - (c - 2)));
      check("f1_coef",   32'(m_coef),   32'(c - 2));
      check("f1_accclr", 32'(m_accclr), (c == 2) ? 32'd1 : 32'd0);
    end
    for (int c = 258; c <= 259; c++) begin
      tick();
      check("f1_drain_macen", 32'(m_macen), 0);
      check("f1_drain_round", 32'(m_round), 0);
      check("f1_drain_idxhi", 32'(m_idxhi), 0);
    end
    tick();  // cycle 260
    check("f1_round", 32'(m_round), 1);
    check("f1_round_push", 32'(m_push), 0);
    tick();  // cycle 261
    check("f1_push", 32'(m_push), 1);
    check("f1_done", 32'(m_done), 1);
    check("f1_out_round", 32'(m_round), 0);
    tick();  // cycle 262
    check("f1_busy_end", 32'(m_busy),  0);
    check("f1_frame",    32'(m_frame), 1);
    check("f1_push_end", 32'(m_push),  0);
    check("f1_overrun",  32'(m_overrun), 0);

    // Stall in OUT for 10 cycles
    m_ready = 1'b0;
    m_filter = 1'b1;
    tick();
    m_filter = 1'b0;
    repeat (260) tick();  // cycle 261
    for (int i = 0; i < 10; i++) begin
      check("st_push", 32'(m_push), 1);
      check("st_done", 32'(m_done), 0);
      check("st_frame", 32'(m_frame), 1);
      tick();
    end
    m_ready = 1'b1;
    #1;
    check("st_push_acc", 32'(m_push), 1);
    check("st_done_acc", 32'(m_done), 1);
    tick();
    check("st_busy_end", 32'(m_busy), 0);
    check("st_frame_end", 32'(m_frame), 2);

    // FILTER held for three frames
    m_filter = 1'b1;
    dones = 0;
    for (int i = 1; i <= 1000 && dones < 3; i++) begin
      tick();
      if (m_load) loads.push_back(i);
      if (m_done) begin
        dones++;
        if (dones == 3) m_filter = 1'b0;
      end
    end
    check("bb_dones", 32'(dones), 3);
    check("bb_loads", 32'(loads.size()), 3);
    if (loads.size() == 3) begin
      check("bb_first", 32'(loads[0]), 1);
      check("bb_gap1", 32'(loads[1] - loads[0]), 262);
      check("bb_gap2", 32'(loads[2] - loads[1]), 262);
    end
    tick();
    check("bb_frame",   32'(m_frame),   5);
    check("bb_overrun", 32'(m_overrun), 1);
    check("bb_busy",    32'(m_busy),    0);

    // Reset in CALC at k=100
    m_filter = 1'b1;
    tick();  // cycle 1
    m_filter = 1'b0;
    repeat (101) tick();  // cycle 102
    check("mr_idxlo", 32'(m_idxlo), 100);
    m_reset = 1'b1;
    tick();
    check("mr_busy",    32'(m_busy),    0);
    check("mr_macen",   32'(m_macen),   0);
    check("mr_idxlo0",  32'(m_idxlo),   0);
    check("mr_frame",   32'(m_frame),   0);
    check("mr_overrun", 32'(m_overrun), 0);
    m_reset = 1'b0;
    m_filter = 1'b1;
    tick();
    m_filter = 1'b0;
    check("mr_load", 32'(m_load), 1);
    tick();
    check("mr_macen_k0", 32'(m_macen),  1);
    check("mr_accclr",   32'(m_accclr), 1);
    check("mr_idxlo_k0", 32'(m_idxlo),  0);
    check("mr_idxhi_k0", 32'(m_idxhi),  511);
    tick();
    check("mr_accclr_k1", 32'(m_accclr), 0);

    // Small instance: NTAPS=8, MAC_LAT=0, 2-bit frame counter
    for (int f = 0; f < 5; f++) begin
      s_filter = 1'b1;
      tick();  // cycle 1
      s_filter = 1'b0;
      check("sm_load", 32'(s_load), 1);
      for (int c = 2; c <= 5; c++) begin
        tick();
        check("sm_macen", 32'(s_macen), 1);
        check("sm_idxhi", 32'(s_idxhi), 32'(7 - (c - 2)));
        check("sm_idxlo", 32'(s_idxlo), 32'(c - 2));
      end
      tick();  // cycle 6
      check("sm_round", 32'(s_round), 1);
      check("sm_round_macen", 32'(s_macen), 0);
      tick();  // cycle 7
      check("sm_push", 32'(s_push), 1);
      check("sm_done", 32'(s_done), 1);
      tick();
      check("sm_busy", 32'(s_busy), 0);
      check("sm_frame", 32'(s_frame), 32'(exp_frame[f]));
    end
    check("sm_overrun", 32'(s_overrun), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
